enc_bundler: RTL

Downstream consumer of enc_binder_pack_2 in the sparse HDC encoder.
- Accumulates per-dimension bit counts of the FEATURES_PER_CC shifted (bound) level hypervectors for each chunk, over NUM_CHUNKS chunks.
- Thresholds the counts into the final query hypervector.
- Presents the result to the associative-memory stage over a valid/ready handshake.

---
 rtl/enc_pkg.sv | 21 ++
 rtl/enc_bundler_popcount.sv | 19 +
 rtl/enc_bundler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared constants, state type and width helper for the sparse HDC encoder datapath.
package enc_pkg;

    localparam int unsigned HV_DIM          = 1024;
    localparam int unsigned FEATURES_PER_CC = 25;
    localparam int unsigned SEG_LEN         = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        THRESH,
        DONE
    } bundler_state_t;

    // Bits needed to hold any count in 0..features*chunks.
    function automatic int unsigned cnt_width(input int unsigned features,
                                              input int unsigned chunks);
        return $clog2(features * chunks + 1);
    endfunction

endpackage

// File: rtl/enc_bundler_popcount.sv
// Combinational population count of N bits; one instance serves one hypervector dimension.
module enc_bundler_popcount
    import enc_pkg::*;
#(
    parameter int unsigned N     = 25,
    parameter int unsigned OUT_W = cnt_width(N, 1)
) (
    input  logic [N-1:0]     bits,
    output logic [OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + OUT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/enc_bundler.sv
// Bundles NUM_CHUNKS chunks of bound hypervectors into a thresholded query hypervector.
// Optional macro ENC_BUNDLER_SEG_THIN_EN selects segmented winner-take-all thresholding.
module enc_bundler
    import enc_pkg::*;
#(
    parameter int unsigned HV_DIM          = enc_pkg::HV_DIM,
    parameter int unsigned FEATURES_PER_CC = enc_pkg::FEATURES_PER_CC,
    parameter int unsigned NUM_CHUNKS      = 5,
    parameter int unsigned THRESHOLD       = 2,
    parameter int unsigned CNT_W           = cnt_width(FEATURES_PER_CC, NUM_CHUNKS)
`ifdef ENC_BUNDLER_SEG_THIN_EN
    ,
    parameter int unsigned SEG_LEN         = enc_pkg::SEG_LEN
`endif
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start_encoding,
    input  logic              in_valid,
    input  logic [HV_DIM-1:0] shifted_hv [0:FEATURES_PER_CC],
    output logic              busy,
    output logic [HV_DIM-1:0] query_hv,
    output logic              hv_valid,
    input  logic              hv_ready
);

    localparam int unsigned POP_W   = cnt_width(FEATURES_PER_CC, 1);
    localparam int unsigned CHUNK_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

    bundler_state_t      state_q, state_d;
    logic [CHUNK_W-1:0]  chunk_cnt_q, chunk_cnt_d;
    logic [CNT_W-1:0]    count_q [HV_DIM];
    logic [CNT_W-1:0]    count_d [HV_DIM];
    logic [HV_DIM-1:0]   query_hv_q, query_hv_d;
    logic                hv_valid_q, hv_valid_d;
    logic [POP_W-1:0]    pop [HV_DIM];
    logic [HV_DIM-1:0]   thresh_hv;
    logic                clear;
    logic                accumulate;

    // The trailing element exists only to match the pack's port shape.
    logic unused_spare;
    assign unused_spare = ^shifted_hv[FEATURES_PER_CC];

    for (genvar d = 0; d < HV_DIM; d++) begin : g_dim
        logic [FEATURES_PER_CC-1:0] column;
        for (genvar f = 0; f < FEATURES_PER_CC; f++) begin : g_feat
            assign column[f] = shifted_hv[f][d];
        end
        enc_bundler_popcount #(
            .N     (FEATURES_PER_CC),
            .OUT_W (POP_W)
        ) u_popcount (
            .bits  (column),
            .count (pop[d])
        );
    end

`ifdef ENC_BUNDLER_SEG_THIN_EN
    localparam int unsigned NUM_SEGS = HV_DIM / SEG_LEN;

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        logic [CNT_W-1:0] best_cnt;
        int unsigned      best_idx;
        thresh_hv = '0;
        best_cnt  = '0;
        best_idx  = 0;
        for (int s = 0; s < NUM_SEGS; s++) begin
            best_cnt = count_q[s * SEG_LEN];
            best_idx = s * SEG_LEN;
            for (int i = 1; i < SEG_LEN; i++) begin
                if (count_q[s * SEG_LEN + i] > best_cnt) begin
                    best_cnt = count_q[s * SEG_LEN + i];
                    best_idx = s * SEG_LEN + i;
                end
            end
            if (32'(best_cnt) >= THRESHOLD) begin
                thresh_hv[best_idx] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        thresh_hv = '0;
        for (int d = 0; d < HV_DIM; d++) begin
            thresh_hv[d] = (32'(count_q[d]) >= THRESHOLD);
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        chunk_cnt_d = chunk_cnt_q;
        query_hv_d  = query_hv_q;
        hv_valid_d  = hv_valid_q;
        clear       = 1'b0;
        accumulate  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_encoding) begin
                    clear   = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (start_encoding) begin
                    clear = 1'b1;
                end else if (in_valid) begin
                    accumulate = 1'b1;
                    if (chunk_cnt_q == LAST_CHUNK) begin
                        chunk_cnt_d = '0;
                        state_d     = THRESH;
                    end else begin
                        chunk_cnt_d = chunk_cnt_q + CHUNK_W'(1);
                    end
                end
            end
            THRESH: begin
                if (start_encoding) begin
                    clear   = 1'b1;
                    state_d = ACCUM;
                end else begin
                    query_hv_d = thresh_hv;
                    hv_valid_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                // A start here only counts when it coincides with the hand-off.
                if (hv_ready) begin
                    hv_valid_d = 1'b0;
                    if (start_encoding) begin
                        clear   = 1'b1;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            chunk_cnt_d = '0;
        end

        for (int d = 0; d < HV_DIM; d++) begin
            if (clear) begin
                count_d[d] = '0;
            end else if (accumulate) begin
                count_d[d] = count_q[d] + CNT_W'(pop[d]);
            end else begin
                count_d[d] = count_q[d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            chunk_cnt_q <= '0;
            query_hv_q  <= '0;
            hv_valid_q  <= 1'b0;
            for (int d = 0; d < HV_DIM; d++) begin
                count_q[d] <= '0;
            end
        end else begin
            state_q     <= state_d;
            chunk_cnt_q <= chunk_cnt_d;
            query_hv_q  <= query_hv_d;
            hv_valid_q  <= hv_valid_d;
            for (int d = 0; d < HV_DIM; d++) begin
                count_q[d] <= count_d[d];
            end
        end
    end

    assign busy     = (state_q == ACCUM) || (state_q == THRESH);
    assign query_hv = query_hv_q;
    assign hv_valid = hv_valid_q;

endmodule
